// File: rtl/fifo_byte_serializer.sv
`default_nettype none
// ============================================================================
// fifo_byte_serializer : pops WIDTH-bit words from a FIFO and emits them as an
// MSB-first byte stream with valid/ready handshaking.      Rev 1.0
// ============================================================================
module fifo_byte_serializer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_empty,
  output logic             fifo_rd_en,
  input  logic [WIDTH-1:0] fifo_dout,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic [15:0]      word_cnt
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    SEND  = 2'd2
  } state_t;

  state_t           state;
  logic [IDXW-1:0]  byte_idx;
  logic [WIDTH-1:0] shreg;
  logic             at_last;
  logic             handshake;

  // Outputs are gated by rst so they read as idle during the reset cycle itself.
  assign at_last    = (byte_idx == LAST_IDX);
  assign m_valid    = !rst && (state == SEND);
  assign m_last     = m_valid && at_last;
  assign m_data     = m_valid ? shreg[WIDTH-1 -: 8] : 8'h00;
  assign handshake  = m_valid && m_ready;
  assign fifo_rd_en = !rst && !fifo_empty &&
                      ((state == IDLE) || (handshake && at_last));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      byte_idx <= '0;
      shreg    <= '0;
      word_cnt <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (fifo_rd_en) state <= FETCH;
        end
        FETCH: begin
          shreg    <= fifo_dout;
          byte_idx <= '0;
          state    <= SEND;
        end
        SEND: begin
          if (m_ready) begin
            if (at_last) begin
              word_cnt <= word_cnt + 16'd1;
              // Chain straight into the next fetch when a word is waiting.
              state    <= fifo_rd_en ? FETCH : IDLE;
            end else begin
              shreg    <= shreg << 8;
              byte_idx <= byte_idx + IDXW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_byte_serializer.sv
`default_nettype none
// Bench for fifo_byte_serializer: byte-stream model plus directed scenarios on a
// 16-bit instance, and a word-counter wrap run on an 8-bit instance.
module tb_fifo_byte_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // 16-bit instance and its upstream FIFO model
  logic        rst = 1'b1;
  logic        m_ready = 1'b1;
  logic        fifo_empty, fifo_rd_en, m_valid, m_last;
  logic [15:0] fifo_dout = 16'h0000;
  logic [15:0] word_cnt;
  logic [7:0]  m_data;

  logic [15:0] fifo_q[$];
  int          fifo_n = 0;
  int          pops = 0;
  logic [8:0]  exp_q[$];   // {last, byte} in expected emission order
  int          mcnt = 0;

  int n_pass = 0;
  int n_chk  = 0;

  assign fifo_empty = (fifo_n == 0);

  fifo_byte_serializer #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_rd_en(fifo_rd_en),
    .fifo_dout(fifo_dout), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_last(m_last), .word_cnt(word_cnt)
  );

  always @(posedge clk) begin
    if (fifo_rd_en && fifo_n > 0) begin
      fifo_dout <= fifo_q.pop_front();
      fifo_n    <= fifo_n - 1;
      pops      <= pops + 1;
    end
  end

  // 8-bit instance: endless source of bytes until 65536 words have been popped
  logic        rst8 = 1'b1;
  logic        empty8 = 1'b0;
  logic        r8 = 1'b1;
  logic        rd8, v8, l8;
  logic [7:0]  dout8 = 8'h00;
  logic [7:0]  d8;
  logic [15:0] cnt8;
  int          k8 = 0;
  int          hs8 = 0;
  logic        wrap_done = 1'b0;

  fifo_byte_serializer #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst8), .fifo_empty(empty8), .fifo_rd_en(rd8),
    .fifo_dout(dout8), .m_data(d8), .m_valid(v8),
    .m_ready(r8), .m_last(l8), .word_cnt(cnt8)
  );

  always @(posedge clk) begin
    if (rd8 && !empty8) begin
      dout8 <= k8[7:0] ^ 8'h5C;
      if (k8 == 65535) empty8 <= 1'b1;
      k8 <= k8 + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Per-cycle comparison of the 16-bit instance against the byte-stream model
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_outputs", 32'({m_valid, m_last, fifo_rd_en, m_data}), 32'd0);
      mcnt = 0;
    end else begin
      chk("word_cnt", 32'(word_cnt), 32'(mcnt[15:0]));
      if (fifo_rd_en) chk("rd_en_while_empty", 32'(fifo_empty), 32'd0);
      if (!m_valid) chk("last_without_valid", 32'(m_last), 32'd0);
      else if (exp_q.size() == 0) chk("unexpected_byte", 32'(m_valid), 32'd0);
      else begin
        chk("byte", 32'({m_last, m_data}), 32'(exp_q[0]));
        if (m_ready) begin
          if (exp_q[0][8]) mcnt++;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // Per-cycle comparison of the 8-bit instance: every byte is last, counter tracks words
  always @(negedge clk) begin
    if (!rst8) begin
      chk("w8_cnt", 32'(cnt8), 32'(hs8[15:0]));
      if (rd8) chk("w8_rd_while_empty", 32'(empty8), 32'd0);
      if (v8) begin
        if (hs8 >= 65536) chk("w8_extra_byte", 32'(v8), 32'd0);
        else chk("w8_byte", 32'({l8, d8}), 32'({1'b1, hs8[7:0] ^ 8'h5C}));
        if (r8) hs8++;
      end else if (hs8 == 65536) begin
        wrap_done = 1'b1;
      end
    end
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst8 = 1'b0;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] w);
    fifo_q.push_back(w);
    fifo_n++;
    exp_q.push_back({1'b0, w[15:8]});
    exp_q.push_back({1'b1, w[7:0]});
  endtask

  task automatic look(input string n, input logic rd, input logic v, input logic l,
                      input logic [7:0] d);
    @(negedge clk);
    chk({n, "_ctl"}, 32'({fifo_rd_en, m_valid, m_last}), 32'({rd, v, l}));
    if (v) chk({n, "_data"}, 32'(m_data), 32'(d));
  endtask

  task automatic cyc(input string n, input logic rd, input logic v, input logic l,
                     input logic [7:0] d);
    step();
    look(n, rd, v, l, d);
  endtask

  // Upstream FIFO is reset alongside the block, so pending words and bytes vanish
  task automatic do_reset();
    step();
    rst = 1'b1;
    fifo_q.delete();
    fifo_n = 0;
    exp_q.delete();
    step();
    rst = 1'b0;
  endtask

  int p0;

  initial begin
    // Single word, loaded while reset is still high
    step();
    push(16'hA55A);
    @(negedge clk);
    chk("t1_rd_in_rst", 32'(fifo_rd_en), 32'd0);
    chk("t1_cnt_rst", 32'(word_cnt), 32'd0);
    step();
    rst = 1'b0;
    look("t1_c0", 1, 0, 0, 8'h00);
    cyc("t1_c1", 0, 0, 0, 8'h00);
    cyc("t1_c2", 0, 1, 0, 8'hA5);
    cyc("t1_c3", 0, 1, 1, 8'h5A);
    cyc("t1_c4", 0, 0, 0, 8'h00);
    chk("t1_cnt", 32'(word_cnt), 32'd1);
    chk("t1_pops", 32'(pops), 32'd1);
    chk("t1_empty", 32'(fifo_empty), 32'd1);

    // Back-to-back words with one FETCH gap between them
    do_reset();
    p0 = pops;
    push(16'h1234);
    push(16'h5678);
    look("t2_c0", 1, 0, 0, 8'h00);
    cyc("t2_c1", 0, 0, 0, 8'h00);
    cyc("t2_c2", 0, 1, 0, 8'h12);
    cyc("t2_c3", 1, 1, 1, 8'h34);
    cyc("t2_c4", 0, 0, 0, 8'h00);
    cyc("t2_c5", 0, 1, 0, 8'h56);
    cyc("t2_c6", 0, 1, 1, 8'h78);
    cyc("t2_c7", 0, 0, 0, 8'h00);
    chk("t2_cnt", 32'(word_cnt), 32'd2);
    chk("t2_pops", 32'(pops - p0), 32'd2);

    // Backpressure on both bytes while a second word waits upstream
    do_reset();
    p0 = pops;
    m_ready = 1'b0;
    push(16'hBEEF);
    look("t3_c0", 1, 0, 0, 8'h00);
    cyc("t3_c1", 0, 0, 0, 8'h00);
    for (int i = 0; i < 5; i++) begin
      step();
      if (i == 0) push(16'h0102);
      look("t3_stall", 0, 1, 0, 8'hBE);
    end
    chk("t3_pops_stalled", 32'(pops - p0), 32'd1);
    step();
    m_ready = 1'b1;
    look("t3_go", 0, 1, 0, 8'hBE);
    step();
    m_ready = 1'b0;
    look("t3_ef_stall", 0, 1, 1, 8'hEF);
    step();
    m_ready = 1'b1;
    look("t3_ef_go", 1, 1, 1, 8'hEF);
    cyc("t3_fetch", 0, 0, 0, 8'h00);
    cyc("t3_b0", 0, 1, 0, 8'h01);
    cyc("t3_b1", 0, 1, 1, 8'h02);
    cyc("t3_idle", 0, 0, 0, 8'h00);
    chk("t3_cnt", 32'(word_cnt), 32'd2);
    chk("t3_pops", 32'(pops - p0), 32'd2);

    // Empty guard
    do_reset();
    for (int i = 0; i < 20; i++) cyc("t4_empty", 0, 0, 0, 8'h00);

    // Reset right after the first byte of 0xABCD is accepted
    do_reset();
    push(16'hABCD);
    look("t5_c0", 1, 0, 0, 8'h00);
    cyc("t5_c1", 0, 0, 0, 8'h00);
    cyc("t5_ab", 0, 1, 0, 8'hAB);
    step();
    rst = 1'b1;
    fifo_q.delete();
    fifo_n = 0;
    exp_q.delete();
    look("t5_in_rst", 0, 0, 0, 8'h00);
    step();
    rst = 1'b0;
    look("t5_after", 0, 0, 0, 8'h00);
    chk("t5_cnt", 32'(word_cnt), 32'd0);
    for (int i = 0; i < 5; i++) cyc("t5_quiet", 0, 0, 0, 8'h00);
    chk("main_stream_drained", 32'(exp_q.size()), 32'd0);

    // Counter wrap on the 8-bit instance
    for (int i = 0; i < 150000 && !wrap_done; i++) @(posedge clk);
    chk("wrap_done", 32'(wrap_done), 32'd1);
    @(negedge clk);
    chk("wrap_cnt", 32'(cnt8), 32'h0000);
    chk("wrap_words", 32'(hs8), 32'd65536);
    chk("wrap_pops", 32'(k8), 32'd65536);
    chk("wrap_idle", 32'({v8, l8, rd8}), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fifo_byte_serializer.md
FIFO_BYTE_SERIALIZER -- requirements
Module: fifo_byte_serializer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16, meaning the bit width of one FIFO word; legal values are multiples of 8, at least 8.
REQ-002 The block SHALL have a derived localparam NBYTES = WIDTH/8, meaning the number of bytes emitted per word.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port fifo_empty, input, 1 bit: empty flag of the upstream FIFO.
REQ-006 The block SHALL have port fifo_rd_en, output, 1 bit: pop request to the upstream FIFO.
REQ-007 The block SHALL have port fifo_dout, input, WIDTH bits: registered read data of the upstream FIFO.
REQ-008 The block SHALL have port m_data, output, 8 bits: the byte currently offered downstream.
REQ-009 The block SHALL have port m_valid, output, 1 bit: m_data is valid.
REQ-010 The block SHALL have port m_ready, input, 1 bit: the downstream accepts the byte.
REQ-011 The block SHALL have port m_last, output, 1 bit: the current byte is the final byte of its word.
REQ-012 The block SHALL have port word_cnt, output, 16 bits: count of fully transmitted words.

Function
REQ-013 Upstream contract: a pop requested in cycle N with fifo_empty low SHALL be treated as presenting valid data on fifo_dout in cycle N+1, and fifo_dout SHALL be treated as holding only until the next pop.
REQ-014 The FSM SHALL have exactly three states: IDLE, FETCH and SEND.
REQ-015 fifo_rd_en SHALL be combinational and SHALL equal !rst && !fifo_empty && (state==IDLE || (state==SEND && m_ready && byte_idx==NBYTES-1)).
REQ-016 IDLE: if fifo_rd_en is high, the next state SHALL be FETCH; otherwise the FSM SHALL remain in IDLE.
REQ-017 FETCH (exactly 1 cycle): the block SHALL load fifo_dout into a WIDTH-bit shift register, SHALL set byte_idx to 0, and the next state SHALL be SEND.
REQ-018 SEND: m_valid SHALL be 1 and m_data SHALL equal shreg[WIDTH-1:WIDTH-8], so bytes go out MSB first.
REQ-019 m_last SHALL equal m_valid && (byte_idx==NBYTES-1).
REQ-020 A handshake SHALL occur in a cycle when m_valid && m_ready; without a handshake, m_data, m_last and the state SHALL be held unchanged.
REQ-021 On a handshake with byte_idx < NBYTES-1, the block SHALL shift shreg left by 8 and increment byte_idx.
REQ-022 On a handshake with byte_idx == NBYTES-1, the block SHALL increment word_cnt, which wraps 0xFFFF -> 0x0000.
REQ-023 On that same final-byte handshake, the next state SHALL be FETCH if fifo_rd_en is high that cycle, else IDLE.
REQ-024 Sustained throughput SHALL be 1 word per NBYTES+1 cycles when the FIFO is non-empty and m_ready is held high.
REQ-025 m_valid SHALL be 0 in IDLE and FETCH.
REQ-026 fifo_rd_en SHALL never be asserted while fifo_empty is high, and SHALL never be asserted in FETCH.
REQ-027 At most one pop SHALL be outstanding at any time; the block SHALL hold no word storage beyond shreg.
REQ-028 For NBYTES==1, every byte SHALL be a last byte, and the block SHALL behave as a 1-word register stage with the same FSM.
REQ-029 fifo_empty falling while the FSM is in SEND SHALL have no effect until the final-byte handshake.

Reset
REQ-030 While rst is high, the block SHALL set state=IDLE, byte_idx=0, shreg=0 and word_cnt=0.
REQ-031 While rst is high, the outputs SHALL be m_valid=0, m_last=0, m_data=0x00 and fifo_rd_en=0.
REQ-032 Reset asserted mid-word (in FETCH or SEND) SHALL discard the in-flight word, and no partial-word completion SHALL be counted.
REQ-033 Restart is the system's responsibility: the system SHALL reset the upstream FIFO in the same cycle.
REQ-034 The first pop after reset SHALL be possible in the first cycle rst is low.

Verification
REQ-035 The bench SHALL cover single word: after reset, FIFO holds 0xA55A, m_ready=1 -> rd_en for 1 cycle, then m_data 0xA5 (m_last=0), then 0x5A (m_last=1), then word_cnt=1 and FSM back to IDLE with fifo_empty=1.
REQ-036 The bench SHALL cover back-to-back: FIFO holds 0x1234, 0x5678, m_ready=1 -> byte stream 12,34,56,78 with 1 gap cycle between words, 2 pops total, word_cnt=2.
REQ-037 The bench SHALL cover backpressure: m_ready=0 for 5 cycles while 0xBEEF is offered -> m_data=0xBE held stable for all 5 cycles, no pop issued, then normal completion.
REQ-038 The bench SHALL cover empty guard: fifo_empty=1 for 20 cycles -> fifo_rd_en=0 and m_valid=0 throughout.
REQ-039 The bench SHALL cover reset mid-word: rst=1 for 1 cycle right after byte 0xAB of 0xABCD is accepted -> next cycle m_valid=0, word_cnt=0, and 0xCD is never emitted.
REQ-040 The bench SHALL cover wrap: word_cnt preloaded by streaming 65536 words -> word_cnt=0x0000, with no other side effects.
